// File: rtl/io_pkg.sv
// Shared definitions for the ЭУВВ output channel: the 5-bit device code
// constants, the producer/consumer state encodings and code-building helpers.
package io_pkg;

    localparam int         CODE_W      = 5;
    localparam logic [3:0] SIGN_PREFIX = 4'b1111;
    localparam logic [1:0] OCT_PREFIX  = 2'b10;
    localparam logic [0:0] DEC_PREFIX  = 1'b1;
    localparam logic [4:0] TERM_CODE   = 5'b00110;

    typedef enum logic [2:0] {
        P_IDLE  = 3'd0,
        P_SIGN  = 3'd1,
        P_DIGIT = 3'd2,
        P_SHIFT = 3'd3,
        P_CSUM  = 3'd4,
        P_TERM  = 3'd5,
        P_DRAIN = 3'd6
    } prod_state_e;

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_RDY  = 2'd1,
        C_ACK  = 2'd2
    } cons_state_e;

    // Device code for one digit; octal uses the top three AU bits.
    function automatic logic [4:0] digit_code(input logic dec, input logic [3:0] digit);
        logic [4:0] code;
        if (dec) begin
            code = {DEC_PREFIX, digit};
        end else begin
            code = {OCT_PREFIX, digit[3:1]};
        end
        return code;
    endfunction

    // Numeric value of the emitted digit, octal digits zero-extended.
    function automatic logic [3:0] digit_value(input logic dec, input logic [3:0] digit);
        logic [3:0] val;
        if (dec) begin
            val = digit;
        end else begin
            val = {1'b0, digit[3:1]};
        end
        return val;
    endfunction

endpackage

// File: rtl/io_code_fifo.sv
// Small synchronous FIFO holding device codes between the digit producer and
// the device handshake. Flush empties it in one cycle. DEPTH is a power of two.
module io_code_fifo
    import io_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = CODE_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (level_q == LW'(DEPTH));
    assign empty     = (level_q == '0);
    assign level     = level_q;
    assign head      = mem_q[rd_ptr_q];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Next pointers, occupancy and storage contents.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/io_out_channel.sv
// ЭУВВ output channel: turns the accumulator word into sign, digit and
// terminator codes, buffers them and hands them to the printer/punch over a
// four-phase rdy/ack handshake. Optional build macro IO_OUT_CHECKSUM_EN adds a
// 4-bit digit checksum code ahead of the terminator.
module io_out_channel
    import io_pkg::*;
#(
    parameter int OCT_DIGITS = 10,
    parameter int DEC_DIGITS = 7,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start_from_op,
    input  logic                          stop_from_pnl,
    input  logic                          dec_mode_from_pnl,
    input  logic                          stop_after_output_from_pnl,
    input  logic                          sign_from_ac,
    input  logic [3:0]                    digit_from_au,
    input  logic                          ac_answer_from_ac,
    output logic                          order_io_to_ac,
    output logic                          shift_3_bit_to_ac,
    output logic                          shift_4_bit_to_ac,
    output logic                          active_to_pnl,
    output logic                          start_pulse_to_pu,
    output logic                          output_rdy_to_dev,
    input  logic                          output_ack_from_dev,
    output logic [4:0]                    output_data_to_dev,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_to_pnl
);

    localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int MAX_DIG = (OCT_DIGITS > DEC_DIGITS) ? OCT_DIGITS : DEC_DIGITS;
    localparam int CNT_W   = $clog2(MAX_DIG + 1);

    prod_state_e       state_q, state_d;
    cons_state_e       cons_q, cons_d;
    logic              mode_q, mode_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              active_q, active_d;
    logic              order_q, order_d;
    logic              start_pulse_q, start_pulse_d;
    logic              rdy_q, rdy_d;
    logic              shift3_q, shift3_d;
    logic              shift4_q, shift4_d;
`ifdef IO_OUT_CHECKSUM_EN
    logic [3:0]        csum_q, csum_d;
`endif

    logic              push_s;
    logic              pop_s;
    logic [4:0]        push_code_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [LVL_W-1:0]  fifo_level_s;
    logic [4:0]        fifo_head_s;
    logic [CNT_W-1:0]  n_digits_s;

    assign n_digits_s = mode_q ? CNT_W'(DEC_DIGITS) : CNT_W'(OCT_DIGITS);

    io_code_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CODE_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (stop_from_pnl),
        .push      (push_s),
        .push_data (push_code_s),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .level     (fifo_level_s)
    );

    // Code to push this cycle; pushing states hold while the FIFO is full.
    always_comb begin
        push_s      = 1'b0;
        push_code_s = TERM_CODE;
        if (!stop_from_pnl && !fifo_full_s) begin
            case (state_q)
                P_SIGN: begin
                    push_s      = 1'b1;
                    push_code_s = {SIGN_PREFIX, sign_from_ac};
                end
                P_DIGIT: begin
                    push_s      = 1'b1;
                    push_code_s = digit_code(mode_q, digit_from_au);
                end
`ifdef IO_OUT_CHECKSUM_EN
                P_CSUM: begin
                    push_s      = 1'b1;
                    push_code_s = {1'b1, csum_q};
                end
`endif
                P_TERM: begin
                    push_s      = 1'b1;
                    push_code_s = TERM_CODE;
                end
                default: begin
                    push_s      = 1'b0;
                    push_code_s = TERM_CODE;
                end
            endcase
        end else begin
            push_s      = 1'b0;
            push_code_s = TERM_CODE;
        end
    end

    // Device handshake: present head, wait for ack, pop on ack release.
    always_comb begin
        cons_d = cons_q;
        pop_s  = 1'b0;
        if (stop_from_pnl) begin
            cons_d = C_IDLE;
        end else begin
            case (cons_q)
                C_IDLE: begin
                    if (push_s || !fifo_empty_s) begin
                        cons_d = C_RDY;
                    end else begin
                        cons_d = C_IDLE;
                    end
                end
                C_RDY: begin
                    if (output_ack_from_dev) begin
                        cons_d = C_ACK;
                    end else begin
                        cons_d = C_RDY;
                    end
                end
                C_ACK: begin
                    if (!output_ack_from_dev) begin
                        pop_s = 1'b1;
                        if ((fifo_level_s > LVL_W'(1)) || push_s) begin
                            cons_d = C_RDY;
                        end else begin
                            cons_d = C_IDLE;
                        end
                    end else begin
                        cons_d = C_ACK;
                    end
                end
                default: cons_d = C_IDLE;
            endcase
        end
        rdy_d = (cons_d == C_RDY);
    end

    // Producer sequencing: sign, N digit/shift pairs, optional checksum, terminator, drain.
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        cnt_d         = cnt_q;
        active_d      = active_q;
        order_d       = 1'b0;
        start_pulse_d = 1'b0;
`ifdef IO_OUT_CHECKSUM_EN
        csum_d        = csum_q;
`endif
        if (stop_from_pnl) begin
            state_d  = P_IDLE;
            active_d = 1'b0;
        end else begin
            case (state_q)
                P_IDLE: begin
                    if (start_from_op) begin
                        state_d  = P_SIGN;
                        mode_d   = dec_mode_from_pnl;
                        cnt_d    = '0;
                        active_d = 1'b1;
`ifdef IO_OUT_CHECKSUM_EN
                        csum_d   = 4'd0;
`endif
                    end else begin
                        state_d = P_IDLE;
                    end
                end
                P_SIGN: begin
                    if (push_s) begin
                        state_d = P_DIGIT;
                    end else begin
                        state_d = P_SIGN;
                    end
                end
                P_DIGIT: begin
                    if (push_s) begin
                        state_d = P_SHIFT;
                        cnt_d   = cnt_q + CNT_W'(1);
                        order_d = 1'b1;
`ifdef IO_OUT_CHECKSUM_EN
                        csum_d  = csum_q + digit_value(mode_q, digit_from_au);
`endif
                    end else begin
                        state_d = P_DIGIT;
                    end
                end
                P_SHIFT: begin
                    if (ac_answer_from_ac) begin
                        if (cnt_q < n_digits_s) begin
                            state_d = P_DIGIT;
                        end else begin
`ifdef IO_OUT_CHECKSUM_EN
                            state_d = P_CSUM;
`else
                            state_d = P_TERM;
`endif
                        end
                    end else begin
                        state_d = P_SHIFT;
                    end
                end
`ifdef IO_OUT_CHECKSUM_EN
                P_CSUM: begin
                    if (push_s) begin
                        state_d = P_TERM;
                    end else begin
                        state_d = P_CSUM;
                    end
                end
`endif
                P_TERM: begin
                    if (push_s) begin
                        state_d = P_DRAIN;
                    end else begin
                        state_d = P_TERM;
                    end
                end
                P_DRAIN: begin
                    // The terminator is the last entry; its pop ends the word.
                    if (pop_s && (fifo_level_s == LVL_W'(1))) begin
                        state_d       = P_IDLE;
                        active_d      = 1'b0;
                        start_pulse_d = !stop_after_output_from_pnl;
                    end else begin
                        state_d = P_DRAIN;
                    end
                end
                default: begin
                    state_d  = P_IDLE;
                    active_d = 1'b0;
                end
            endcase
        end
        shift3_d = active_d && !mode_d;
        shift4_d = active_d && mode_d;
    end

    // Producer, handshake and registered output flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= P_IDLE;
            cons_q        <= C_IDLE;
            mode_q        <= 1'b0;
            cnt_q         <= '0;
            active_q      <= 1'b0;
            order_q       <= 1'b0;
            start_pulse_q <= 1'b0;
            rdy_q         <= 1'b0;
            shift3_q      <= 1'b0;
            shift4_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cons_q        <= cons_d;
            mode_q        <= mode_d;
            cnt_q         <= cnt_d;
            active_q      <= active_d;
            order_q       <= order_d;
            start_pulse_q <= start_pulse_d;
            rdy_q         <= rdy_d;
            shift3_q      <= shift3_d;
            shift4_q      <= shift4_d;
        end
    end

`ifdef IO_OUT_CHECKSUM_EN
    // Running checksum of emitted digit values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum_q <= 4'd0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    assign order_io_to_ac     = order_q;
    assign shift_3_bit_to_ac  = shift3_q;
    assign shift_4_bit_to_ac  = shift4_q;
    assign active_to_pnl      = active_q;
    assign start_pulse_to_pu  = start_pulse_q;
    assign output_rdy_to_dev  = rdy_q;
    assign output_data_to_dev = fifo_head_s;
    assign fifo_level_to_pnl  = fifo_level_s;

endmodule

// File: tb/tb_io_out_channel.sv
// Directed bench for io_out_channel: behavioural AU and device responders,
// one task per scenario with inline hand-computed expectations.
module tb_io_out_channel;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_main, start_dev;
    logic       stop_from_pnl;
    logic       dec_mode_from_pnl;
    logic       stop_after_output_from_pnl;
    logic       sign_from_ac;
    logic [3:0] digit_from_au;
    logic       au_ans, man_ans;
    logic       order_io_to_ac, shift_3_bit_to_ac, shift_4_bit_to_ac;
    logic       active_to_pnl, start_pulse_to_pu, output_rdy_to_dev;
    logic       output_ack_from_dev;
    logic [4:0] output_data_to_dev;
    logic [2:0] fifo_level_to_pnl;

    wire start_from_op     = start_main | start_dev;
    wire ac_answer_from_ac = au_ans | man_ans;

    int checks = 0;
    int errors = 0;
    int order_cnt = 0;
    int start_cnt = 0;
    int rx_cnt = 0;
    logic [4:0] rx_mem [0:255];

    logic au_en  = 1'b0;
    logic dev_en = 1'b0;
    logic dev_start_on_release = 1'b0;
    int   dev_delay = 3;
    int   dev_hold  = 1;

`ifdef IO_OUT_CHECKSUM_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    io_out_channel #(.OCT_DIGITS(10), .DEC_DIGITS(7), .FIFO_DEPTH(4)) dut (
        .clk                        (clk),
        .reset                      (reset),
        .start_from_op              (start_from_op),
        .stop_from_pnl              (stop_from_pnl),
        .dec_mode_from_pnl          (dec_mode_from_pnl),
        .stop_after_output_from_pnl (stop_after_output_from_pnl),
        .sign_from_ac               (sign_from_ac),
        .digit_from_au              (digit_from_au),
        .ac_answer_from_ac          (ac_answer_from_ac),
        .order_io_to_ac             (order_io_to_ac),
        .shift_3_bit_to_ac          (shift_3_bit_to_ac),
        .shift_4_bit_to_ac          (shift_4_bit_to_ac),
        .active_to_pnl              (active_to_pnl),
        .start_pulse_to_pu          (start_pulse_to_pu),
        .output_rdy_to_dev          (output_rdy_to_dev),
        .output_ack_from_dev        (output_ack_from_dev),
        .output_data_to_dev         (output_data_to_dev),
        .fifo_level_to_pnl          (fifo_level_to_pnl)
    );

    always #5 clk = ~clk;

    // Pulse counters.
    always @(posedge clk) begin
        if (order_io_to_ac)    order_cnt <= order_cnt + 1;
        if (start_pulse_to_pu) start_cnt <= start_cnt + 1;
    end

    // AU model: answer each shift order two cycles later.
    initial begin
        au_ans = 1'b0;
        forever begin
            @(negedge clk);
            if (au_en && order_io_to_ac) begin
                repeat (2) @(negedge clk);
                au_ans = 1'b1;
                @(negedge clk);
                au_ans = 1'b0;
            end
        end
    end

    // Device model: record code, ack after dev_delay, release after dev_hold.
    initial begin
        output_ack_from_dev = 1'b0;
        start_dev = 1'b0;
        forever begin
            @(negedge clk);
            start_dev = 1'b0;
            if (dev_en && output_rdy_to_dev) begin
                rx_mem[rx_cnt[7:0]] = output_data_to_dev;
                rx_cnt = rx_cnt + 1;
                repeat (dev_delay - 1) @(negedge clk);
                output_ack_from_dev = 1'b1;
                repeat (dev_hold) @(negedge clk);
                if (dev_start_on_release && fifo_level_to_pnl == 3'd1) start_dev = 1'b1;
                output_ack_from_dev = 1'b0;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start_main = 1'b1;
        @(negedge clk);
        start_main = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (active_to_pnl !== 1'b0) begin errors++; $display("FAIL reset_active got %b want 0", active_to_pnl); end
        checks++; if (output_rdy_to_dev !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b want 0", output_rdy_to_dev); end
        checks++; if (output_data_to_dev !== 5'd0) begin errors++; $display("FAIL reset_data got %b want 00000", output_data_to_dev); end
        checks++; if (fifo_level_to_pnl !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level_to_pnl); end
        checks++; if ({order_io_to_ac, shift_3_bit_to_ac, shift_4_bit_to_ac, start_pulse_to_pu} !== 4'b0000) begin
            errors++; $display("FAIL reset_pulses got %b want 0000", {order_io_to_ac, shift_3_bit_to_ac, shift_4_bit_to_ac, start_pulse_to_pu});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_octal();
        int rx0, ord0, st0, k;
        rx0 = rx_cnt; ord0 = order_cnt; st0 = start_cnt;
        au_en = 1'b1; dev_en = 1'b1; dev_delay = 3; dev_hold = 1;
        dec_mode_from_pnl = 1'b0; sign_from_ac = 1'b0; digit_from_au = 4'b1010;
        @(negedge clk);
        start_main = 1'b1;
        @(negedge clk);
        start_main = 1'b0;
        checks++; if (active_to_pnl !== 1'b1) begin errors++; $display("FAIL oct_active got %b want 1", active_to_pnl); end
        checks++; if ({shift_3_bit_to_ac, shift_4_bit_to_ac} !== 2'b10) begin errors++; $display("FAIL oct_shift got %b want 10", {shift_3_bit_to_ac, shift_4_bit_to_ac}); end
        @(negedge clk);
        checks++; if (output_rdy_to_dev !== 1'b1 || output_data_to_dev !== 5'b11110) begin
            errors++; $display("FAIL oct_first_rdy got rdy=%b data=%b want rdy=1 data=11110", output_rdy_to_dev, output_data_to_dev);
        end
        k = 0;
        while (active_to_pnl === 1'b1 && k < 800) begin @(negedge clk); k++; end
        @(negedge clk);
        checks++; if (active_to_pnl !== 1'b0) begin errors++; $display("FAIL oct_timeout got active=%b want 0", active_to_pnl); end
        checks++; if (rx_cnt - rx0 !== 12 + EXTRA) begin errors++; $display("FAIL oct_count got %0d want %0d", rx_cnt - rx0, 12 + EXTRA); end
        for (int i = 0; i < 12 + EXTRA; i++) begin
            logic [4:0] exp;
            if (i == 0) exp = 5'b11110;
            else if (i <= 10) exp = 5'b10101;
            else if (i == 11 && EXTRA == 1) exp = 5'b10010;
            else exp = 5'b00110;
            checks++; if (rx_mem[(rx0 + i) % 256] !== exp) begin errors++; $display("FAIL oct_code[%0d] got %b want %b", i, rx_mem[(rx0 + i) % 256], exp); end
        end
        checks++; if (order_cnt - ord0 !== 10) begin errors++; $display("FAIL oct_orders got %0d want 10", order_cnt - ord0); end
        checks++; if (start_cnt - st0 !== 1) begin errors++; $display("FAIL oct_start_pulse got %0d want 1", start_cnt - st0); end
        checks++; if ({shift_3_bit_to_ac, shift_4_bit_to_ac} !== 2'b00) begin errors++; $display("FAIL oct_shift_idle got %b want 00", {shift_3_bit_to_ac, shift_4_bit_to_ac}); end
    endtask

    task automatic test_decimal_stall();
        int rx0, ord0, st0, k;
        rx0 = rx_cnt; ord0 = order_cnt; st0 = start_cnt;
        au_en = 1'b1; dev_en = 1'b0;
        dec_mode_from_pnl = 1'b1; sign_from_ac = 1'b1; digit_from_au = 4'h9;
        pulse_start();
        repeat (30) @(negedge clk);
        checks++; if (fifo_level_to_pnl !== 3'd4) begin errors++; $display("FAIL dec_stall_level got %0d want 4", fifo_level_to_pnl); end
        checks++; if (output_rdy_to_dev !== 1'b1 || output_data_to_dev !== 5'b11111) begin
            errors++; $display("FAIL dec_stall_head got rdy=%b data=%b want rdy=1 data=11111", output_rdy_to_dev, output_data_to_dev);
        end
        checks++; if ({shift_3_bit_to_ac, shift_4_bit_to_ac} !== 2'b01) begin errors++; $display("FAIL dec_shift got %b want 01", {shift_3_bit_to_ac, shift_4_bit_to_ac}); end
        checks++; if (order_cnt - ord0 !== 3) begin errors++; $display("FAIL dec_stall_orders got %0d want 3", order_cnt - ord0); end
        dev_en = 1'b1;
        k = 0;
        while (active_to_pnl === 1'b1 && k < 800) begin @(negedge clk); k++; end
        @(negedge clk);
        checks++; if (active_to_pnl !== 1'b0) begin errors++; $display("FAIL dec_timeout got active=%b want 0", active_to_pnl); end
        checks++; if (rx_cnt - rx0 !== 9 + EXTRA) begin errors++; $display("FAIL dec_count got %0d want %0d", rx_cnt - rx0, 9 + EXTRA); end
        for (int i = 0; i < 9 + EXTRA; i++) begin
            logic [4:0] exp;
            if (i == 0) exp = 5'b11111;
            else if (i <= 7) exp = 5'b11001;
            else if (i == 8 && EXTRA == 1) exp = 5'b11111;
            else exp = 5'b00110;
            checks++; if (rx_mem[(rx0 + i) % 256] !== exp) begin errors++; $display("FAIL dec_code[%0d] got %b want %b", i, rx_mem[(rx0 + i) % 256], exp); end
        end
        checks++; if (order_cnt - ord0 !== 7) begin errors++; $display("FAIL dec_orders got %0d want 7", order_cnt - ord0); end
        checks++; if (start_cnt - st0 !== 1) begin errors++; $display("FAIL dec_start_pulse got %0d want 1", start_cnt - st0); end
    endtask

    task automatic test_stop_after_output();
        int rx0, st0, k;
        rx0 = rx_cnt; st0 = start_cnt;
        au_en = 1'b1; dev_en = 1'b1; dev_delay = 1;
        stop_after_output_from_pnl = 1'b1;
        dec_mode_from_pnl = 1'b0; sign_from_ac = 1'b0; digit_from_au = 4'b0010;
        pulse_start();
        k = 0;
        while (active_to_pnl === 1'b1 && k < 800) begin @(negedge clk); k++; end
        repeat (3) @(negedge clk);
        checks++; if (active_to_pnl !== 1'b0) begin errors++; $display("FAIL soa_active got %b want 0", active_to_pnl); end
        checks++; if (rx_cnt - rx0 !== 12 + EXTRA) begin errors++; $display("FAIL soa_count got %0d want %0d", rx_cnt - rx0, 12 + EXTRA); end
        checks++; if (rx_mem[(rx0 + 1) % 256] !== 5'b10001) begin errors++; $display("FAIL soa_digit got %b want 10001", rx_mem[(rx0 + 1) % 256]); end
        checks++; if (start_cnt - st0 !== 0) begin errors++; $display("FAIL soa_no_pulse got %0d want 0", start_cnt - st0); end
        stop_after_output_from_pnl = 1'b0;
    endtask

    task automatic test_stop_in_shift();
        int st0, ord0, k;
        st0 = start_cnt;
        au_en = 1'b0; dev_en = 1'b0;
        dec_mode_from_pnl = 1'b0; sign_from_ac = 1'b1; digit_from_au = 4'b1110;
        pulse_start();
        k = 0;
        while (order_io_to_ac !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        checks++; if (order_io_to_ac !== 1'b1) begin errors++; $display("FAIL stop_shift_order got %b want 1", order_io_to_ac); end
        checks++; if (fifo_level_to_pnl !== 3'd2) begin errors++; $display("FAIL stop_shift_level_pre got %0d want 2", fifo_level_to_pnl); end
        @(negedge clk);
        checks++; if (order_io_to_ac !== 1'b0) begin errors++; $display("FAIL stop_shift_order_width got %b want 0", order_io_to_ac); end
        stop_from_pnl = 1'b1;
        @(negedge clk);
        stop_from_pnl = 1'b0;
        checks++; if (fifo_level_to_pnl !== 3'd0 || output_rdy_to_dev !== 1'b0 || active_to_pnl !== 1'b0) begin
            errors++; $display("FAIL stop_shift_clear got level=%0d rdy=%b active=%b want 0 0 0", fifo_level_to_pnl, output_rdy_to_dev, active_to_pnl);
        end
        ord0 = order_cnt;
        man_ans = 1'b1;
        @(negedge clk);
        man_ans = 1'b0;
        repeat (15) @(negedge clk);
        checks++; if (active_to_pnl !== 1'b0 || fifo_level_to_pnl !== 3'd0 || output_rdy_to_dev !== 1'b0) begin
            errors++; $display("FAIL stop_shift_late_answer got active=%b level=%0d rdy=%b want 0 0 0", active_to_pnl, fifo_level_to_pnl, output_rdy_to_dev);
        end
        checks++; if (order_cnt - ord0 !== 0 || start_cnt - st0 !== 0) begin
            errors++; $display("FAIL stop_shift_pulses got orders=%0d starts=%0d want 0 0", order_cnt - ord0, start_cnt - st0);
        end
    endtask

    task automatic test_stop_in_ack();
        int st0, k;
        st0 = start_cnt;
        au_en = 1'b1; dev_en = 1'b1; dev_delay = 1; dev_hold = 6;
        dec_mode_from_pnl = 1'b1; sign_from_ac = 1'b0; digit_from_au = 4'h3;
        pulse_start();
        k = 0;
        while (!(output_ack_from_dev === 1'b1 && output_rdy_to_dev === 1'b0) && k < 30) begin @(negedge clk); k++; end
        checks++; if (output_ack_from_dev !== 1'b1 || output_rdy_to_dev !== 1'b0) begin
            errors++; $display("FAIL stop_ack_phase got ack=%b rdy=%b want 1 0", output_ack_from_dev, output_rdy_to_dev);
        end
        stop_from_pnl = 1'b1;
        @(negedge clk);
        stop_from_pnl = 1'b0;
        checks++; if (fifo_level_to_pnl !== 3'd0 || output_rdy_to_dev !== 1'b0 || active_to_pnl !== 1'b0) begin
            errors++; $display("FAIL stop_ack_clear got level=%0d rdy=%b active=%b want 0 0 0", fifo_level_to_pnl, output_rdy_to_dev, active_to_pnl);
        end
        repeat (30) @(negedge clk);
        checks++; if (active_to_pnl !== 1'b0 || fifo_level_to_pnl !== 3'd0 || output_rdy_to_dev !== 1'b0 || start_cnt - st0 !== 0) begin
            errors++; $display("FAIL stop_ack_after got active=%b level=%0d rdy=%b starts=%0d want 0 0 0 0", active_to_pnl, fifo_level_to_pnl, output_rdy_to_dev, start_cnt - st0);
        end
        dev_hold = 1;
    endtask

    task automatic test_ignored_start();
        int rx0, st0, k;
        rx0 = rx_cnt; st0 = start_cnt;
        au_en = 1'b1; dev_en = 1'b1; dev_delay = 2; dev_hold = 1;
        dec_mode_from_pnl = 1'b0; sign_from_ac = 1'b1; digit_from_au = 4'b0110;
        pulse_start();
        repeat (5) @(negedge clk);
        dec_mode_from_pnl = 1'b1;
        pulse_start();
        checks++; if ({shift_3_bit_to_ac, shift_4_bit_to_ac} !== 2'b10) begin errors++; $display("FAIL ign_mode_kept got %b want 10", {shift_3_bit_to_ac, shift_4_bit_to_ac}); end
        dev_start_on_release = 1'b1;
        k = 0;
        while (active_to_pnl === 1'b1 && k < 800) begin @(negedge clk); k++; end
        dev_start_on_release = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (active_to_pnl !== 1'b0) begin errors++; $display("FAIL ign_final_pop_start got active=%b want 0", active_to_pnl); end
        checks++; if (rx_cnt - rx0 !== 12 + EXTRA) begin errors++; $display("FAIL ign_count got %0d want %0d", rx_cnt - rx0, 12 + EXTRA); end
        checks++; if (rx_mem[rx0 % 256] !== 5'b11111) begin errors++; $display("FAIL ign_sign got %b want 11111", rx_mem[rx0 % 256]); end
        checks++; if (rx_mem[(rx0 + 10) % 256] !== 5'b10011) begin errors++; $display("FAIL ign_digit got %b want 10011", rx_mem[(rx0 + 10) % 256]); end
        if (EXTRA == 1) begin
            checks++; if (rx_mem[(rx0 + 11) % 256] !== 5'b11110) begin errors++; $display("FAIL ign_csum got %b want 11110", rx_mem[(rx0 + 11) % 256]); end
        end
        checks++; if (start_cnt - st0 !== 1) begin errors++; $display("FAIL ign_start_pulse got %0d want 1", start_cnt - st0); end
    endtask

    initial begin
        reset = 1'b1;
        start_main = 1'b0;
        stop_from_pnl = 1'b0;
        dec_mode_from_pnl = 1'b0;
        stop_after_output_from_pnl = 1'b0;
        sign_from_ac = 1'b0;
        digit_from_au = 4'd0;
        man_ans = 1'b0;
        test_reset();
        test_octal();
        test_decimal_stall();
        test_stop_after_output();
        test_stop_in_shift();
        test_stop_in_ack();
        test_ignored_start();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_out_channel.md
# io_out_channel

Parametrised output channel of ЭУВВ. Converts the accumulator word into a stream of 5-bit device codes: sign, N octal or decimal digits, terminator. It buffers the codes in a FIFO and drives them to the printer/punch over a four-phase rdy/ack handshake. Digit extraction runs ahead of the slow device, so the arithmetic unit is released as soon as the last digit is buffered, not when it is printed.

## Interface
- OCT_DIGITS, 10: digits per word in octal mode (3 bits each)
- DEC_DIGITS, 7: digits per word in decimal mode (4 bits each)
- FIFO_DEPTH, 4: code buffer entries; power of two, ≥2
- clk  in  1  clock; all flops on rising edge
- reset  in  1  asynchronous, active-high
- start_from_op  in  1  pulse; begin output of one word
- stop_from_pnl  in  1  pulse; abort and flush
- dec_mode_from_pnl  in  1  level; 0 = octal, 1 = decimal; sampled at start
- stop_after_output_from_pnl  in  1  level; suppress the completion start pulse
- sign_from_ac  in  1  value; word sign
- digit_from_au  in  4  value; top 4 bits of the AU register
- ac_answer_from_ac  in  1  pulse; shift complete
- order_io_to_ac  out  1  pulse; request a left shift
- shift_3_bit_to_ac, shift_4_bit_to_ac  out  1 each  level; shift width
- active_to_pnl  out  1  level; word in progress
- start_pulse_to_pu  out  1  pulse; word fully delivered
- output_rdy_to_dev  out  1  handshake
- output_ack_from_dev  in  1  handshake
- output_data_to_dev  out  5  code, valid while rdy is high
- fifo_level_to_pnl  out  clog2(FIFO_DEPTH)+1  occupancy

## Operation
- Code formats:
  - sign: {4'b1111, sign}
  - octal digit: {2'b10, digit[3:1]}
  - decimal digit: {1'b1, digit}
  - terminator: 5'b00110
- Producer FSM states: IDLE, SIGN, DIGIT, SHIFT, CSUM, TERM, DRAIN.
  - IDLE → SIGN on start_from_op. Latch the mode, clear the digit counter, set active. A start while active is ignored.
  - SIGN, DIGIT, CSUM, TERM each push one code, only when the FIFO is not full; otherwise they hold.
  - SIGN → DIGIT.
  - DIGIT: push, increment the counter, pulse order_io_to_ac, → SHIFT.
  - SHIFT: wait for ac_answer_from_ac. → DIGIT if counter < N, else → CSUM (macro on) or TERM.
  - TERM → DRAIN.
  - DRAIN → IDLE once the terminator has been popped and the FIFO is empty. In that cycle: pulse start_pulse_to_pu unless stop_after_output_from_pnl; clear active.
- N = OCT_DIGITS or DEC_DIGITS, chosen by the latched mode. Every digit is followed by exactly one shift, so N shifts occur per word.
- shift_3/shift_4 follow the latched mode while active; both are 0 when idle.
- Consumer handshake, four-phase:
  - RDY: rdy=1 and data=FIFO head, whenever the FIFO is non-empty.
  - ack=1 → ACK: rdy=0, data held.
  - ack=0 → pop, return to RDY or idle.
- Push and pop in the same cycle are allowed; occupancy is unchanged.
- stop_from_pnl has priority over all other inputs. It sends the producer to IDLE, empties the FIFO, drops rdy and clears active. No start pulse is issued. An ac_answer arriving after an abort is ignored.

## Timing
- Reset values:
  - all outputs 0
  - FIFO empty
  - producer IDLE, consumer idle
- Latency:
  - start_from_op → sign code pushed: next cycle
  - push → output_rdy_to_dev high: next cycle
- order_io_to_ac is high for exactly 1 cycle, in the cycle after the digit push.
- ack low → pop: same edge. The next code's rdy rises on the following cycle.
- The producer stalls on a full FIFO only. The sign and digit values are sampled in the push cycle.
- start_pulse_to_pu is high for exactly 1 cycle.

## Configuration
- IO_OUT_CHECKSUM_EN defined:
  - the CSUM state is present;
  - a 4-bit wrap-around sum of the emitted digit values is accumulated (octal digits zero-extended);
  - the sum is pushed as {1'b1, sum} before the terminator.
- IO_OUT_CHECKSUM_EN undefined: SHIFT goes directly to TERM and the word is N+2 codes.

## Structure
- Shared package io_pkg holds:
  - the code constants (SIGN prefix, OCT/DEC prefixes, TERM = 5'b00110);
  - the producer state enum.
- Sub-module io_code_fifo: synchronous FIFO, parameters DEPTH and WIDTH=5, ports push/pop/full/empty/level.

## Test plan
- Octal word, sign=0, digits 3'b101 repeated, ack returned 3 cycles after rdy:
  - device receives 5'b11110, ten copies of 5'b10101, then 5'b00110;
  - exactly 10 order_io_to_ac pulses;
  - one start_pulse_to_pu.
- Decimal word, sign=1, digit 4'h9, device never acks:
  - producer stalls with FIFO level at 4;
  - releasing ack drains 9 codes total: 5'b11111, 7×5'b11001, 5'b00110.
- stop_after_output_from_pnl=1: complete word, no start_pulse_to_pu, active_to_pnl drops after the terminator pop.
- stop_from_pnl mid-word, during SHIFT and during an ACK phase:
  - FIFO level 0 and rdy 0 the next cycle;
  - later ac_answer ignored;
  - no start pulse.
- Second start_from_op while active is ignored; start in the same cycle as the final pop is also ignored.
- IO_OUT_CHECKSUM_EN, decimal mode, all digits 4'h9: checksum code 5'b11111 (63 mod 16 = 15) precedes 5'b00110.
